// File: rtl/timer_pkg.sv
// Shared constants and helpers for the cascaded timer digit counters.
package timer_pkg;

    localparam int DIGIT_W_DEFAULT = 4;
    localparam int VEC_MAX_W       = 256;
    localparam int DIGIT_MAX_W     = 16;

    // Per-digit moduli, most significant digit first in the literal.
    localparam logic [7:0] SEC_MODULI  = {4'd6, 4'd10};
    localparam logic [7:0] HOUR_MODULI = {4'd2, 4'd10};

    // Extracts digit i (w bits wide) from a digit-packed vector.
    function automatic logic [DIGIT_MAX_W-1:0] dig(
        input logic [VEC_MAX_W-1:0] vec,
        input int                   i,
        input int                   w
    );
        logic [VEC_MAX_W-1:0] mask;
        mask = (VEC_MAX_W'(1) << w) - VEC_MAX_W'(1);
        return DIGIT_MAX_W'((vec >> (i * w)) & mask);
    endfunction

endpackage

// File: rtl/timer_digit_chain_mod_digit.sv
// One modulo-MOD up/down digit with clamped parallel load.
module mod_digit #(
    parameter int DIGIT_W = 4,
    parameter int MOD     = 10
) (
    input  logic               clock,
    input  logic               clrn,
    input  logic               load,
    input  logic [DIGIT_W-1:0] ld_val,
    input  logic               en,
    input  logic               up,
    input  logic               hold,
    output logic [DIGIT_W-1:0] value,
    output logic               term,
    output logic               clamped
);

    localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(MOD - 1);
    localparam logic [DIGIT_W-1:0] ONE     = DIGIT_W'(1);

    logic [DIGIT_W-1:0] value_q, value_d;

    assign clamped = (ld_val > MAX_VAL);
    assign term    = up ? (value_q == MAX_VAL) : (value_q == '0);
    assign value   = value_q;

    // Next digit value: load beats counting; a held or idle digit keeps its value.
    always_comb begin
        // NOTE: default assignment first so every path drives value_d and no latch is inferred.
        value_d = value_q;
        if (load) begin
            value_d = clamped ? MAX_VAL : ld_val;
        end else if (en && !hold) begin
            if (up) value_d = term ? '0 : value_q + ONE;
            else    value_d = term ? MAX_VAL : value_q - ONE;
        end
    end

    // Digit register with asynchronous clear.
    always_ff @(posedge clock or negedge clrn) begin
        // NOTE: non-blocking assignment so all registers update together at the edge.
        if (!clrn) value_q <= '0;
        else       value_q <= value_d;
    end

endmodule

// File: rtl/timer_digit_chain.sv
// Cascaded chain of modulo-M up/down digits with stop-at-zero, clamped load
// and registered done / load-error pulses.
module timer_digit_chain
    import timer_pkg::*;
#(
    parameter int                              NUM_DIGITS   = 2,
    parameter int                              DIGIT_W      = DIGIT_W_DEFAULT,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]   MODULI       = SEC_MODULI,
    parameter bit                              STOP_AT_ZERO = 1'b1
) (
    input  logic                          clock,
    input  logic                          clrn,
    input  logic                          loadn,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] data,
    input  logic                          enable,
    input  logic                          up,
    output logic [NUM_DIGITS*DIGIT_W-1:0] count,
    output logic                          zero,
    output logic                          tc,
    output logic                          done,
    output logic                          load_err
);

    localparam int                   TOTAL_W    = NUM_DIGITS * DIGIT_W;
    localparam logic [TOTAL_W-1:0]   ONE        = TOTAL_W'(1);
    localparam logic [VEC_MAX_W-1:0] MODULI_EXT = VEC_MAX_W'(MODULI);

    logic [NUM_DIGITS:0]   en;
    logic [NUM_DIGITS-1:0] term;
    logic [NUM_DIGITS-1:0] clamped;
    logic                  hold;
    logic                  done_q, done_d;
    logic                  load_err_q, load_err_d;

    assign en[0] = enable;
    // Freeze the whole chain at zero when counting down in stop-at-zero mode.
    assign hold  = STOP_AT_ZERO & ~up & enable & zero;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        // A raw slice of zero encodes a modulus of 2**DIGIT_W.
        localparam int MOD_RAW = int'(dig(MODULI_EXT, i, DIGIT_W));
        localparam int MOD     = (MOD_RAW == 0) ? (1 << DIGIT_W) : MOD_RAW;

        mod_digit #(
            .DIGIT_W (DIGIT_W),
            .MOD     (MOD)
        ) u_digit (
            .clock   (clock),
            .clrn    (clrn),
            .load    (~loadn),
            .ld_val  (data[i*DIGIT_W +: DIGIT_W]),
            .en      (en[i]),
            .up      (up),
            .hold    (hold),
            .value   (count[i*DIGIT_W +: DIGIT_W]),
            .term    (term[i]),
            .clamped (clamped[i])
        );

        assign en[i+1] = en[i] & term[i];
    end

    assign zero       = (count == '0);
    assign tc         = en[NUM_DIGITS];
    assign done_d     = loadn & enable & ~up & (count == ONE);
    assign load_err_d = ~loadn & (|clamped);
    assign done       = done_q;
    assign load_err   = load_err_q;

    // Status pulse registers: each lasts exactly one cycle unless re-triggered.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

endmodule

// File: tb/tb_timer_digit_chain.sv
// Directed bench for timer_digit_chain: default seconds chain, wrapping
// variant and a three-digit mod-80 chain.
module tb_timer_digit_chain;

    logic clock = 1'b0;
    logic clrn  = 1'b0;

    always #5 clock = ~clock;

    // Default instance: seconds, stop at zero.
    logic       a_loadn = 1'b1, a_enable = 1'b0, a_up = 1'b0;
    logic [7:0] a_data = '0, a_count;
    logic       a_zero, a_tc, a_done, a_load_err;

    // Wrapping instance.
    logic       w_loadn = 1'b1, w_enable = 1'b0, w_up = 1'b0;
    logic [7:0] w_data = '0, w_count;
    logic       w_zero, w_tc, w_done, w_load_err;

    // Three-digit instance, moduli {2,4,10}.
    logic        t_loadn = 1'b1, t_enable = 1'b0, t_up = 1'b0;
    logic [11:0] t_data = '0, t_count;
    logic        t_zero, t_tc, t_done, t_load_err;

    int n_cmp = 0;
    int n_err = 0;

    timer_digit_chain dut (
        .clock(clock), .clrn(clrn), .loadn(a_loadn), .data(a_data),
        .enable(a_enable), .up(a_up), .count(a_count), .zero(a_zero),
        .tc(a_tc), .done(a_done), .load_err(a_load_err)
    );

    timer_digit_chain #(.STOP_AT_ZERO(1'b0)) dut_w (
        .clock(clock), .clrn(clrn), .loadn(w_loadn), .data(w_data),
        .enable(w_enable), .up(w_up), .count(w_count), .zero(w_zero),
        .tc(w_tc), .done(w_done), .load_err(w_load_err)
    );

    timer_digit_chain #(.NUM_DIGITS(3), .MODULI({4'd2, 4'd4, 4'd10})) dut3 (
        .clock(clock), .clrn(clrn), .loadn(t_loadn), .data(t_data),
        .enable(t_enable), .up(t_up), .count(t_count), .zero(t_zero),
        .tc(t_tc), .done(t_done), .load_err(t_load_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        a_enable = 1'b1; a_up = 1'b0;
        #1;
        n_cmp++; if (a_count !== 8'h00) begin n_err++; $display("FAIL reset_count got %h want 00", a_count); end
        n_cmp++; if (a_zero !== 1'b1) begin n_err++; $display("FAIL reset_zero got %b want 1", a_zero); end
        n_cmp++; if (a_done !== 1'b0 || a_load_err !== 1'b0) begin n_err++; $display("FAIL reset_flags got %b%b want 00", a_done, a_load_err); end
        n_cmp++; if (a_tc !== 1'b1) begin n_err++; $display("FAIL reset_tc_down got %b want 1", a_tc); end
        a_up = 1'b1;
        #1;
        n_cmp++; if (a_tc !== 1'b0) begin n_err++; $display("FAIL reset_tc_up got %b want 0", a_tc); end
        a_enable = 1'b0;
        #2 clrn = 1'b1;
        // Mid-count asynchronous clear: load 0x36, count up to 0x37, then clear.
        tick();
        a_loadn = 1'b0; a_data = 8'h36;
        tick();
        a_loadn = 1'b1; a_enable = 1'b1; a_up = 1'b1;
        tick();
        n_cmp++; if (a_count !== 8'h37) begin n_err++; $display("FAIL pre_clear_count got %h want 37", a_count); end
        #2 clrn = 1'b0;
        #1;
        n_cmp++; if (a_count !== 8'h00 || a_zero !== 1'b1 || a_done !== 1'b0) begin
            n_err++; $display("FAIL async_clear got count=%h zero=%b done=%b want 00/1/0", a_count, a_zero, a_done);
        end
        a_enable = 1'b0;
        #1 clrn = 1'b1;
    endtask

    task automatic test_down_count();
        logic [7:0] exp_c;
        tick();
        a_loadn = 1'b0; a_data = 8'h12; a_enable = 1'b0; a_up = 1'b0;
        tick();
        n_cmp++; if (a_count !== 8'h12 || a_load_err !== 1'b0) begin n_err++; $display("FAIL load_12 got %h err=%b want 12 err=0", a_count, a_load_err); end
        a_loadn = 1'b1; a_enable = 1'b1;
        for (int v = 11; v >= 0; v--) begin
            tick();
            exp_c = {4'(v / 10), 4'(v % 10)};
            n_cmp++; if (a_count !== exp_c) begin n_err++; $display("FAIL down_count got %h want %h", a_count, exp_c); end
            n_cmp++; if (a_done !== (v == 0)) begin n_err++; $display("FAIL down_done at %h got %b want %b", exp_c, a_done, (v == 0)); end
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (a_count !== 8'h00 || a_done !== 1'b0) begin n_err++; $display("FAIL hold_zero got %h done=%b want 00 done=0", a_count, a_done); end
            n_cmp++; if (a_tc !== 1'b1 || a_zero !== 1'b1) begin n_err++; $display("FAIL hold_tc got tc=%b zero=%b want 1/1", a_tc, a_zero); end
        end
        a_enable = 1'b0;
    endtask

    task automatic test_wrap();
        w_loadn = 1'b0; w_data = 8'h00; w_enable = 1'b0;
        tick();
        n_cmp++; if (w_count !== 8'h00 || w_done !== 1'b0) begin n_err++; $display("FAIL load_zero got %h done=%b want 00 done=0", w_count, w_done); end
        w_loadn = 1'b1; w_enable = 1'b1; w_up = 1'b0;
        tick();
        n_cmp++; if (w_count !== 8'h59 || w_done !== 1'b0) begin n_err++; $display("FAIL wrap_down got %h done=%b want 59 done=0", w_count, w_done); end
        w_up = 1'b1;
        #1;
        n_cmp++; if (w_tc !== 1'b1) begin n_err++; $display("FAIL wrap_up_tc got %b want 1", w_tc); end
        tick();
        n_cmp++; if (w_count !== 8'h00 || w_tc !== 1'b0) begin n_err++; $display("FAIL wrap_up got %h tc=%b want 00 tc=0", w_count, w_tc); end
        w_enable = 1'b0;
    endtask

    task automatic test_load_clamp();
        a_loadn = 1'b0; a_data = 8'h7C;
        tick();
        n_cmp++; if (a_count !== 8'h59 || a_load_err !== 1'b1) begin n_err++; $display("FAIL clamp_7C got %h err=%b want 59 err=1", a_count, a_load_err); end
        a_loadn = 1'b1;
        tick();
        n_cmp++; if (a_count !== 8'h59 || a_load_err !== 1'b0) begin n_err++; $display("FAIL clamp_clear got %h err=%b want 59 err=0", a_count, a_load_err); end
        a_loadn = 1'b0; a_data = 8'h0A;
        tick();
        n_cmp++; if (a_count !== 8'h09 || a_load_err !== 1'b1) begin n_err++; $display("FAIL clamp_0A got %h err=%b want 09 err=1", a_count, a_load_err); end
        a_data = 8'h25;
        tick();
        n_cmp++; if (a_count !== 8'h25 || a_load_err !== 1'b0) begin n_err++; $display("FAIL load_25 got %h err=%b want 25 err=0", a_count, a_load_err); end
        a_loadn = 1'b1;
    endtask

    task automatic test_priority();
        a_loadn = 1'b0; a_data = 8'h30; a_enable = 1'b0;
        tick();
        a_data = 8'h44; a_enable = 1'b1; a_up = 1'b0;
        tick();
        n_cmp++; if (a_count !== 8'h44 || a_done !== 1'b0) begin n_err++; $display("FAIL load_priority got %h done=%b want 44 done=0", a_count, a_done); end
        a_loadn = 1'b1;
        tick();
        n_cmp++; if (a_count !== 8'h43) begin n_err++; $display("FAIL after_load_down got %h want 43", a_count); end
    endtask

    task automatic test_back_to_back();
        a_up = 1'b1;
        tick();
        n_cmp++; if (a_count !== 8'h44) begin n_err++; $display("FAIL dir_up got %h want 44", a_count); end
        a_up = 1'b0;
        tick();
        n_cmp++; if (a_count !== 8'h43) begin n_err++; $display("FAIL dir_down got %h want 43", a_count); end
        a_enable = 1'b0;
        tick();
        n_cmp++; if (a_count !== 8'h43 || a_done !== 1'b0) begin n_err++; $display("FAIL idle_hold got %h done=%b want 43 done=0", a_count, a_done); end
    endtask

    task automatic test_param();
        logic [11:0] exp_c;
        int          tc_hits;
        int          m;
        tc_hits = 0;
        m = 0;
        t_loadn = 1'b0; t_data = 12'h000;
        tick();
        t_loadn = 1'b1; t_enable = 1'b1; t_up = 1'b1;
        for (int k = 0; k < 80; k++) begin
            #1;
            exp_c = {4'(m / 40), 4'((m / 10) % 4), 4'(m % 10)};
            n_cmp++; if (t_count !== exp_c) begin n_err++; $display("FAIL p3_count got %h want %h", t_count, exp_c); end
            n_cmp++; if (t_tc !== (m == 79)) begin n_err++; $display("FAIL p3_tc at %h got %b want %b", exp_c, t_tc, (m == 79)); end
            if (t_tc === 1'b1) tc_hits++;
            tick();
            m = (m + 1) % 80;
        end
        n_cmp++; if (t_count !== 12'h000) begin n_err++; $display("FAIL p3_return got %h want 000", t_count); end
        n_cmp++; if (tc_hits !== 1) begin n_err++; $display("FAIL p3_tc_hits got %0d want 1", tc_hits); end
        t_enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_down_count();
        test_wrap();
        test_load_clamp();
        test_priority();
        test_back_to_back();
        test_param();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
